// File: rtl/cfg_reg_arbiter_if.sv
// Write-side bus of the config register bank: two requester ports plus commit status.
// A transfer happens on a port when valid && ready at a rising clock edge. The requester holds
// valid/addr/data stable until it sees ready. Ready is combinational and never waits on the other port's ready.
interface cfg_reg_arbiter_if #(
    parameter int ADDR_W = 7
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [7:0]        a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [7:0]        b_data;
    logic              wr_done;
    logic              wr_err;
    logic              wr_src;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, wr_done, wr_err, wr_src
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, wr_done, wr_err, wr_src
    );
endinterface

// File: rtl/cfg_reg_arbiter.sv
// Register bank with a round-robin two-port write arbiter and a one-deep commit stage.
// Writes accepted at edge N land in the bank at edge N+1, with a one-cycle wr_done pulse.
module cfg_reg_arbiter #(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cfg_reg_arbiter_if.slave      bus,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [7:0]            rd_data,
    output logic [8*NUM_REGS-1:0] cfg_regs,
    output logic [7:0]            uo_out
);

    typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

    src_e              last_grant;
    logic              grant_a;
    logic              grant_b;
    logic              stg_valid;
    src_e              stg_src;
    logic [ADDR_W-1:0] stg_addr;
    logic [7:0]        stg_data;
    logic              stg_in_range;
    logic [7:0]        regs [NUM_REGS];

    // On contention, the port that lost the previous grant wins. Both readies are held low during reset.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n) begin
            if (bus.a_valid && (!bus.b_valid || last_grant == SRC_B)) begin
                grant_a = 1'b1;
            end else if (bus.b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign bus.a_ready = grant_a;
    assign bus.b_ready = grant_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SRC_B;
        end else if (grant_a) begin
            last_grant <= SRC_A;
        end else if (grant_b) begin
            last_grant <= SRC_B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= 1'b0;
            stg_src   <= SRC_A;
            stg_addr  <= '0;
            stg_data  <= '0;
        end else if (grant_a) begin
            stg_valid <= 1'b1;
            stg_src   <= SRC_A;
            stg_addr  <= bus.a_addr;
            stg_data  <= bus.a_data;
        end else if (grant_b) begin
            stg_valid <= 1'b1;
            stg_src   <= SRC_B;
            stg_addr  <= bus.b_addr;
            stg_data  <= bus.b_data;
        end else begin
            stg_valid <= 1'b0;
        end
    end

    // The full address is compared, so high addresses never alias onto the bank.
    assign stg_in_range = (stg_addr < ADDR_W'(NUM_REGS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (stg_valid && stg_in_range) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (stg_addr == ADDR_W'(i)) begin
                    regs[i] <= stg_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_done <= 1'b0;
            bus.wr_err  <= 1'b0;
            bus.wr_src  <= 1'b0;
        end else if (stg_valid) begin
            bus.wr_done <= 1'b1;
            bus.wr_err  <= !stg_in_range;
            bus.wr_src  <= stg_src;
        end else begin
            bus.wr_done <= 1'b0;
            bus.wr_err  <= 1'b0;
            bus.wr_src  <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = regs[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_regs[8*g +: 8] = regs[g];
    end

    assign uo_out = regs[0];

endmodule

// File: doc/cfg_reg_arbiter.md
# cfg_reg_arbiter

Shared configuration register bank with a two-port write arbiter. Write requests from the SPI front end (port A) and from an on-chip sequencer (port B) contend for one write slot per cycle. Grants are round-robin. Each accepted write commits to the bank one clock later. Register 0 is mirrored to `uo_out`, and the full bank is exported flat to downstream blocks such as the PWM and output-enable logic.

## Interface
- `NUM_REGS`, 5, number of 8-bit registers; valid addresses are 0..NUM_REGS-1
- `ADDR_W`, 7, request address width
- `clk`  in  1  system clock; all state is on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `a_valid`  in  1  port A write request
- `a_ready`  out  1  port A request accepted this cycle
- `a_addr`  in  ADDR_W  port A register address
- `a_data`  in  8  port A write data
- `b_valid`, `b_ready`, `b_addr`, `b_data`: same as port A, for port B
- `wr_done`  out  1  one-cycle pulse; a write completed
- `wr_err`  out  1  qualifies `wr_done`; address was out of range and nothing was written
- `wr_src`  out  1  qualifies `wr_done`; 0 = port A, 1 = port B
- `rd_addr`  in  ADDR_W  read address
- `rd_data`  out  8  combinational read of `regs[rd_addr]`; 0 when out of range
- `cfg_regs`  out  8*NUM_REGS  flat bank; `regs[i]` sits at bits [8i+7:8i]
- `uo_out`  out  8  equals `regs[0]`

## Operation
- **Handshake**
  - A transfer occurs on a port when valid && ready at a rising edge.
  - Requesters hold valid, addr and data stable until ready is seen.
  - Ready is combinational from the valids and the `last_grant` flop. It never depends on the other port's ready.
- **Arbitration**, one grant per cycle:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the port that did not win the most recent grant.
  - `last_grant` updates only on an accepted transfer.
  - `last_grant` resets to B, so A wins the first contended cycle.
- **Fairness:** with both ports continuously valid, grants alternate A, B, A, B. Neither port waits more than 1 cycle.
- **Commit stage:** one register holding {valid, src, addr, data}.
  - Loaded on every accepted transfer.
  - Cleared in a cycle with no transfer.
  - No back-pressure: the stage drains every cycle, so throughput is 1 write per cycle.
- **Commit**, at the edge after acceptance:
  - If addr < NUM_REGS: `regs[addr]` <= data and `wr_err` <= 0.
  - Otherwise: no bank change and `wr_err` <= 1.
  - `wr_done` <= 1 and `wr_src` <= stage src.
  - The address compare uses all ADDR_W bits. An address of 127 is out of range; there is no aliasing or wrap.
- **Back-to-back writes** to the same address: the later commit wins. With 2 writes in 2 consecutive cycles, the final value is the second write's data.
- **Read/write interaction:** a read of the address being committed returns the old value until the commit edge, then the new value.
- **Idle:** `wr_done`, `wr_err` and `wr_src` are 0 in any cycle following an edge with no commit.

## Timing
- **Reset** (async assert on `rst_n` low; deassertion sampled synchronously):
  - All regs = 0x00, so `uo_out` = 0x00 and `cfg_regs` = 0.
  - Commit stage invalid.
  - `wr_done` = 0, `wr_err` = 0, `wr_src` = 0.
  - `last_grant` = B.
- **Ready during reset:** `a_ready` and `b_ready` are forced to 0 while `rst_n` is low.
- **Reset mid-operation:** a staged, uncommitted write is discarded and does not reach the bank.
- **Latency, for a transfer accepted at edge N:**
  - Bank, `cfg_regs` and `uo_out` update at edge N+1.
  - `wr_done` is high for exactly the cycle from N+1 to N+2, with `rd_data` already showing the new value.
- **Ready timing:** ready rises in the same cycle as valid (zero-cycle acceptance) whenever the port wins arbitration.
- **Simultaneous valids:** exactly one ready is high. Never both.

## Test plan
- **Reset values:** assert `rst_n` = 0 mid-write (A accepted with addr 0, data 0xA5, reset before the commit edge). Required: `uo_out` = 0x00 after release, no `wr_done`, all `cfg_regs` = 0.
- **Single write and latency:** A writes addr 0, data 0x3C. Required:
  - `a_ready` high in the same cycle.
  - `uo_out` = 0x3C one edge later.
  - `wr_done` = 1, `wr_src` = 0, `wr_err` = 0 for exactly 1 cycle.
- **Contention:** A and B both continuously valid for 6 cycles, A to addr 1 with data 0x11..0x16, B to addr 2 with data 0x21..0x26. Required:
  - Grant sequence A, B, A, B, A, B.
  - `wr_src` sequence 0, 1, 0, 1, 0, 1.
  - Final regs[1] = 0x13, regs[2] = 0x23, with each port's valid/data held until accepted.
- **Out-of-range writes:** B writes addr 5, then addr 127. Required: `wr_done` = 1 and `wr_err` = 1 on both, no change in `cfg_regs`, and `rd_data` = 0 for `rd_addr` = 5.
- **Back-to-back same address:** A writes addr 4 with 0x80, then 0x81 on the next cycle. Required: `rd_data`(4) reads 0x80 then 0x81 on consecutive cycles, with 2 `wr_done` pulses.
- **Fairness reset state:** first contended cycle after reset. Required: A is granted.
